// File: rtl/fpu_pkg.sv
// Shared FP32 add/sub types: operand word, result flags and the result record
// carried from the pipe into the collector's FIFO.
package fpu_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fpu_flags_t;

    typedef struct packed {
        fp32_t      z;
        fpu_flags_t f;
    } fpu_result_t;

    localparam fp32_t FP32_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO; full/empty come from the occupancy count, so the
// pointers may wrap freely.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fpu_result_t              push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fpu_result_t              head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    fpu_result_t   mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately unreset; the consumer masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fpu_addsub_issue_collector.sv
// Issue/collect controller for the FP32 add/sub pipe: credit-based issue so the
// non-stalling pipe can never overrun the in-order result FIFO.
module fpu_addsub_issue_collector
    import fpu_pkg::*;
#(
    parameter int unsigned L_ADD = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_a,
    input  logic [31:0]              s_b,
    input  logic                     s_add_sub,
    output logic                     p_valid_in,
    output logic [31:0]              p_a,
    output logic [31:0]              p_b,
    output logic                     p_add_sub,
    input  logic                     p_valid_out,
    input  logic [31:0]              p_z,
    input  logic                     p_overflow,
    input  logic                     p_underflow,
    input  logic                     p_zero,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_z,
    output logic [2:0]               m_flags,
    output logic [$clog2(DEPTH):0]   o_inflight,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          ready_en;
    logic          err_q;
    logic          issue;
    logic          push;
    logic          stray;
    logic          pop;
    fpu_result_t   push_data;
    fpu_result_t   head;

    // Ready depends only on registered state; ready_en holds it low until the
    // first clock after reset release.
    assign used       = {1'b0, inflight} + {1'b0, count};
    assign s_ready    = ready_en && (used < CREDITS);
    assign issue      = s_valid && s_ready;
    assign p_valid_in = issue;
    assign p_a        = s_a;
    assign p_b        = s_b;
    assign p_add_sub  = s_add_sub;

    assign push  = p_valid_out && (inflight != '0);
    assign stray = p_valid_out && (inflight == '0);
    assign pop   = m_valid && m_ready;

    always_comb begin
        push_data = {p_z, p_overflow, p_underflow, p_zero};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            err_q    <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            err_q    <= err_q | stray;
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign m_valid    = (count != '0);
    assign m_z        = m_valid ? head.z : FP32_ZERO;
    assign m_flags    = m_valid ? head.f : '0;
    assign o_inflight = inflight;
    assign o_count    = count;
    assign o_err      = err_q;

    // A pipe without backpressure returns every op after L_ADD cycles.
    assert property (@(posedge clk) disable iff (!rst_n) 32'(inflight) <= L_ADD);

endmodule

// File: tb/tb_fpu_addsub_issue_collector.sv
// Directed bench for the issue/collect controller with a behavioural 2-cycle
// pipe that returns hand-computed FP32 results.
module tb_fpu_addsub_issue_collector;
    import fpu_pkg::*;

    localparam int unsigned L_ADD = 2;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_add_sub;
    logic [31:0] s_a, s_b;
    logic        p_valid_in, p_add_sub, p_valid_out;
    logic [31:0] p_a, p_b, p_z;
    logic        p_overflow, p_underflow, p_zero;
    logic        m_valid, m_ready;
    logic [31:0] m_z;
    logic [2:0]  m_flags;
    logic [2:0]  o_inflight, o_count;
    logic        o_err;

    logic        inject;
    logic        v1, v2;
    logic [34:0] r1, r2;

    int errors = 0;
    int checks = 0;

    fp32_t op_a  [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                         32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    fp32_t exp_z [8] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
                         32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};

    always #5 clk = ~clk;

    fpu_addsub_issue_collector #(
        .L_ADD (L_ADD),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
        .s_add_sub   (s_add_sub),
        .p_valid_in  (p_valid_in),
        .p_a         (p_a),
        .p_b         (p_b),
        .p_add_sub   (p_add_sub),
        .p_valid_out (p_valid_out),
        .p_z         (p_z),
        .p_overflow  (p_overflow),
        .p_underflow (p_underflow),
        .p_zero      (p_zero),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_z         (m_z),
        .m_flags     (m_flags),
        .o_inflight  (o_inflight),
        .o_count     (o_count),
        .o_err       (o_err)
    );

    // Result table for the operand pairs the bench issues: {z, ovf, unf, zero}.
    function automatic logic [34:0] pipe_calc(input fp32_t a, input fp32_t b, input logic sub);
        if (!sub && b == FP32_ONE) begin
            for (int k = 0; k < 8; k++)
                if (a == op_a[k]) return {exp_z[k], 3'b000};
        end
        if (!sub && a == FP32_ONE && b == 32'h4000_0000) return {32'h4040_0000, 3'b000};
        if (sub && a == FP32_ONE && b == FP32_ONE)       return {FP32_ZERO, 3'b001};
        if (!sub && a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {32'h7F80_0000, 3'b100};
        return {a ^ b, 3'b000};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            r1 <= '0;
            r2 <= '0;
        end else begin
            v1 <= p_valid_in;
            r1 <= pipe_calc(p_a, p_b, p_add_sub);
            v2 <= v1;
            r2 <= r1;
        end
    end

    assign p_valid_out = v2 | inject;
    assign {p_z, p_overflow, p_underflow, p_zero} = r2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_add_sub = 1'b0;
        m_ready = 1'b0; inject = 1'b0;
        #2;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", o_inflight); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
        checks++; if (p_valid_in !== 1'b0) begin errors++; $display("FAIL reset_p_valid_in got=%b exp=0", p_valid_in); end
        checks++; if (m_z !== 32'h0 || m_flags !== 3'b000) begin errors++; $display("FAIL reset_head got=%h/%b exp=0/000", m_z, m_flags); end
        step;
        rst_n = 1'b1;
        step;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_single;
        m_ready = 1'b1;
        s_valid = 1'b1; s_a = FP32_ONE; s_b = 32'h4000_0000; s_add_sub = 1'b0;
        #1;
        checks++; if (p_valid_in !== 1'b1) begin errors++; $display("FAIL single_issue got=%b exp=1", p_valid_in); end
        checks++; if (p_a !== FP32_ONE || p_b !== 32'h4000_0000) begin errors++; $display("FAIL single_passthru got=%h,%h exp=3f800000,40000000", p_a, p_b); end
        step;
        s_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (m_valid !== (c == 2)) begin errors++; $display("FAIL single_m_valid c=%0d got=%b exp=%b", c, m_valid, c == 2); end
            if (c == 2) begin
                checks++; if (m_z !== 32'h4040_0000) begin errors++; $display("FAIL single_z got=%h exp=40400000", m_z); end
                checks++; if (m_flags !== 3'b000) begin errors++; $display("FAIL single_flags got=%b exp=000", m_flags); end
            end
            step;
        end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL single_inflight got=%0d exp=0", o_inflight); end
    endtask

    task automatic test_back_to_back;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                s_valid = 1'b1; s_a = op_a[i]; s_b = FP32_ONE; s_add_sub = 1'b0;
                #1;
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready i=%0d got=%b exp=1", i, s_ready); end
            end else begin
                s_valid = 1'b0;
            end
            step;
            checks++; if (m_valid !== (i >= 2 && i <= 9)) begin errors++; $display("FAIL b2b_m_valid i=%0d got=%b exp=%b", i, m_valid, (i >= 2 && i <= 9)); end
            if (i >= 2 && i <= 9) begin
                checks++; if (m_z !== exp_z[i-2]) begin errors++; $display("FAIL b2b_z i=%0d got=%h exp=%h", i, m_z, exp_z[i-2]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int accepts = 0;
        int idx = 0;
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_valid = 1'b1; s_a = op_a[accepts < 8 ? accepts : 7]; s_b = FP32_ONE; s_add_sub = 1'b0;
            #1;
            if (s_ready) accepts++;
            step;
        end
        checks++; if (accepts != 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", accepts); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", s_ready); end
        checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", o_count); end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL bp_inflight got=%0d exp=0", o_inflight); end
        checks++; if (m_z !== exp_z[0]) begin errors++; $display("FAIL bp_head got=%h exp=%h", m_z, exp_z[0]); end
        s_a = op_a[4];
        m_ready = 1'b1;
        step;
        m_ready = 1'b0;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_credit_ready got=%b exp=1", s_ready); end
        checks++; if (o_count !== 3'd3) begin errors++; $display("FAIL bp_count_pop got=%0d exp=3", o_count); end
        checks++; if (p_valid_in !== 1'b1) begin errors++; $display("FAIL bp_reissue got=%b exp=1", p_valid_in); end
        step;
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_credit_used got=%b exp=0", s_ready); end
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_valid) begin
                checks++;
                if (idx >= 4) begin errors++; $display("FAIL bp_extra got=%h exp=none", m_z); end
                else if (m_z !== exp_z[idx+1]) begin errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", idx, m_z, exp_z[idx+1]); end
                idx++;
            end
            step;
        end
        checks++; if (idx != 4) begin errors++; $display("FAIL bp_drained got=%0d exp=4", idx); end
    endtask

    task automatic run_one(input fp32_t a, input fp32_t b, input logic sub,
                           output fp32_t z, output logic [2:0] f, output logic seen);
        m_ready = 1'b1;
        s_valid = 1'b1; s_a = a; s_b = b; s_add_sub = sub;
        step;
        s_valid = 1'b0;
        seen = 1'b0; z = '0; f = '0;
        for (int c = 0; c < 8; c++) begin
            if (!seen && m_valid) begin z = m_z; f = m_flags; seen = 1'b1; end
            step;
        end
    endtask

    task automatic test_flags;
        fp32_t z;
        logic [2:0] f;
        logic seen;
        run_one(FP32_ONE, FP32_ONE, 1'b1, z, f, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL flags_sub_timeout got=%b exp=1", seen); end
        checks++; if (z !== FP32_ZERO) begin errors++; $display("FAIL flags_sub_z got=%h exp=00000000", z); end
        checks++; if (f !== 3'b001) begin errors++; $display("FAIL flags_sub_f got=%b exp=001", f); end
        run_one(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, z, f, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL flags_ovf_timeout got=%b exp=1", seen); end
        checks++; if (f[2] !== 1'b1) begin errors++; $display("FAIL flags_ovf_f got=%b exp=1xx", f); end
    endtask

    task automatic test_error;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_pre got=%b exp=0", o_err); end
        inject = 1'b1;
        step;
        inject = 1'b0;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", o_err); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL err_count got=%0d exp=0", o_count); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL err_m_valid got=%b exp=0", m_valid); end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL err_inflight got=%0d exp=0", o_inflight); end
        repeat (3) step;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", o_err); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL err_m_valid_late got=%b exp=0", m_valid); end
    endtask

    task automatic test_reset_mid;
        logic seen_any = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_a = op_a[i]; s_b = FP32_ONE; s_add_sub = 1'b0;
            step;
        end
        s_valid = 1'b0;
        #1;
        checks++; if (o_inflight !== 3'd2 || o_count !== 3'd2) begin errors++; $display("FAIL rst_pre got=%0d/%0d exp=2/2", o_inflight, o_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL rst_inflight got=%0d exp=0", o_inflight); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", o_err); end
        step;
        step;
        rst_n = 1'b1;
        step;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            seen_any = seen_any | m_valid | (o_inflight != 3'd0);
            step;
        end
        checks++; if (seen_any !== 1'b0) begin errors++; $display("FAIL rst_stale got=%b exp=0", seen_any); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_flags;
        test_error;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
